// File: rtl/multi_channel_measure_pkg.sv
// Shared types and helpers for the windowed multi-channel measurement block.
// Holds the FSM state encoding and the 16-bit frequency saturation used by every channel.
package multi_channel_measure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_CALC = 2'd2,
    ST_PUB  = 2'd3
  } state_t;

  localparam int FREQ_W = 16;

  // Clamp a wide frequency product to the 16-bit result field.
  function automatic logic [FREQ_W-1:0] sat_u16(input logic [63:0] v);
    return (v > 64'(16'hFFFF)) ? {FREQ_W{1'b1}} : v[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/multi_channel_measure_if.sv
// Sample/control inputs and published result bus of the measurement block.
// master drives samples and mode controls; slave is the measurement engine.
interface multi_channel_measure_if
  import multi_channel_measure_pkg::*;
#(
  parameter int N      = 8,
  parameter int NUM_CH = 2
);
  logic                     sample_en;
  logic [NUM_CH*N-1:0]      data_in;
  logic                     mode_cont;
  logic                     start;
  logic                     busy;
  logic                     meas_valid;
  logic [NUM_CH*N-1:0]      vpp;
  logic [NUM_CH*N-1:0]      dc_offset;
  logic [NUM_CH*FREQ_W-1:0] freq_out;
  logic [NUM_CH-1:0]        cross_ovf;

  modport master (
    output sample_en, data_in, mode_cont, start,
    input  busy, meas_valid, vpp, dc_offset, freq_out, cross_ovf
  );

  modport slave (
    input  sample_en, data_in, mode_cont, start,
    output busy, meas_valid, vpp, dc_offset, freq_out, cross_ovf
  );
endinterface

// File: rtl/multi_channel_measure_stats.sv
// Per-channel window statistics: min/max/sum, hysteresis crossing counter and the
// mid-level that tracks the previous window's DC. Results are registered on latch.
module multi_channel_measure_stats
  import multi_channel_measure_pkg::*;
#(
  parameter int          N        = 8,
  parameter int          LOG2_WIN = 9,
  parameter int unsigned FS_HZ    = 20000,
  parameter int          HYST     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sample,
  input  logic              latch,
  input  logic [N-1:0]      x,
  output logic [N-1:0]      vpp,
  output logic [N-1:0]      dc,
  output logic [FREQ_W-1:0] freq,
  output logic              ovf
);
  localparam int SUM_W = N + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN;

  logic [N-1:0]      min_reg, max_reg, mid_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              armed_reg;
  logic [N-1:0]      vpp_reg, dc_reg;
  logic [FREQ_W-1:0] freq_reg;
  logic              ovf_reg;

  logic [N:0]        hi_ext;
  logic [N-1:0]      hi, lo;
  logic [N-1:0]      dc_calc;
  logic [63:0]       prod;
  logic [FREQ_W-1:0] freq_calc;

  always_comb begin
    hi_ext    = {1'b0, mid_reg} + (N+1)'(HYST);
    hi        = hi_ext[N] ? {N{1'b1}} : hi_ext[N-1:0];
    lo        = (mid_reg < N'(HYST)) ? {N{1'b0}} : mid_reg - N'(HYST);
    dc_calc   = sum_reg[SUM_W-1:LOG2_WIN];
    prod      = 64'(cnt_reg) * 64'(FS_HZ);
    freq_calc = sat_u16(prod >> LOG2_WIN);
  end

  // min starts at all-ones and max at zero so the first sample loads both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_reg   <= {N{1'b1}};
      max_reg   <= {N{1'b0}};
      sum_reg   <= '0;
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
      mid_reg   <= {1'b1, {(N-1){1'b0}}};
    end else begin
      if (clr) begin
        min_reg   <= {N{1'b1}};
        max_reg   <= {N{1'b0}};
        sum_reg   <= '0;
        cnt_reg   <= '0;
        armed_reg <= 1'b0;
      end else if (sample) begin
        if (x < min_reg) min_reg <= x;
        if (x > max_reg) max_reg <= x;
        sum_reg <= sum_reg + SUM_W'(x);
        if (armed_reg && (x > hi)) begin
          if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + CNT_W'(1);
          armed_reg <= 1'b0;
        end else if (x < lo) begin
          armed_reg <= 1'b1;
        end
      end
      if (latch) mid_reg <= dc_calc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpp_reg  <= '0;
      dc_reg   <= '0;
      freq_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (latch) begin
      vpp_reg  <= max_reg - min_reg;
      dc_reg   <= dc_calc;
      freq_reg <= freq_calc;
      ovf_reg  <= &cnt_reg;
    end
  end

  assign vpp  = vpp_reg;
  assign dc   = dc_reg;
  assign freq = freq_reg;
  assign ovf  = ovf_reg;

endmodule

// File: rtl/multi_channel_measure.sv
// Windowed multi-channel Vpp / DC / frequency measurement: window FSM and counter,
// one statistics block per channel, and packing of the per-channel results.
module multi_channel_measure
  import multi_channel_measure_pkg::*;
#(
  parameter int          N        = 8,
  parameter int          NUM_CH   = 2,
  parameter int          LOG2_WIN = 9,
  parameter int unsigned FS_HZ    = 20000,
  parameter int          HYST     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_channel_measure_if.slave bus
);
  state_t              state_reg, state_next;
  logic [LOG2_WIN-1:0] win_cnt_reg;
  logic                meas_valid_reg;
  logic                clr, sample, latch;

  logic [NUM_CH-1:0][N-1:0]      vpp_w, dc_w;
  logic [NUM_CH-1:0][FREQ_W-1:0] freq_w;
  logic [NUM_CH-1:0]             ovf_w;

  always_comb begin
    state_next = state_reg;
    clr        = 1'b0;
    sample     = 1'b0;
    latch      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start || bus.mode_cont) begin
          state_next = ST_ACQ;
          clr        = 1'b1;
        end
      end
      ST_ACQ: begin
        if (bus.sample_en) begin
          sample = 1'b1;
          if (win_cnt_reg == {LOG2_WIN{1'b1}}) state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        latch      = 1'b1;
        state_next = ST_PUB;
      end
      ST_PUB: begin
        // mode_cont is sampled here, so a drop during ACQ still finishes the window.
        if (bus.mode_cont) begin
          state_next = ST_ACQ;
          clr        = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      win_cnt_reg    <= '0;
      meas_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      meas_valid_reg <= latch;
      if (clr) win_cnt_reg <= '0;
      else if (sample) win_cnt_reg <= win_cnt_reg + LOG2_WIN'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      multi_channel_measure_stats #(
        .N        (N),
        .LOG2_WIN (LOG2_WIN),
        .FS_HZ    (FS_HZ),
        .HYST     (HYST)
      ) u_stats (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .sample (sample),
        .latch  (latch),
        .x      (bus.data_in[gi*N +: N]),
        .vpp    (vpp_w[gi]),
        .dc     (dc_w[gi]),
        .freq   (freq_w[gi]),
        .ovf    (ovf_w[gi])
      );
    end
  endgenerate

  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.meas_valid = meas_valid_reg;
  assign bus.vpp        = vpp_w;
  assign bus.dc_offset  = dc_w;
  assign bus.freq_out   = freq_w;
  assign bus.cross_ovf  = ovf_w;

endmodule

// File: tb/tb_multi_channel_measure.sv
// Randomized bench for multi_channel_measure: stimulus patterns per channel, window
// results predicted from the recorded samples with plain arithmetic.
module tb_multi_channel_measure;
  localparam int          N        = 8;
  localparam int          NUM_CH   = 2;
  localparam int          LOG2_WIN = 9;
  localparam int          WIN      = 512;
  localparam int unsigned FS_HZ    = 20000;
  localparam int          HYST     = 4;

  localparam int P_CONST  = 0;
  localparam int P_SQUARE = 1;
  localparam int P_NOISE  = 2;
  localparam int P_ALT    = 3;
  localparam int P_RAND   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  int pat   [NUM_CH];
  int phase [NUM_CH];
  int mid   [NUM_CH];
  int win   [NUM_CH][WIN];
  int e_vpp [NUM_CH];
  int e_dc  [NUM_CH];
  int e_freq[NUM_CH];
  int e_ovf [NUM_CH];

  multi_channel_measure_if #(.N(N), .NUM_CH(NUM_CH)) bus ();

  multi_channel_measure #(
    .N(N), .NUM_CH(NUM_CH), .LOG2_WIN(LOG2_WIN), .FS_HZ(FS_HZ), .HYST(HYST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int gen(input int ch, input int k);
    case (pat[ch])
      P_CONST:  return 128;
      P_SQUARE: return (((k + phase[ch]) % 20) < 10) ? 8'h40 : 8'hC0;
      P_NOISE:  return 125 + int'($urandom_range(0, 6));
      P_ALT:    return (((k + phase[ch]) % 2) == 0) ? 8'h00 : 8'hFF;
      default:  return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Window result straight from the recorded samples; mid carries over as the new DC.
  function automatic void model_window();
    int mn, mx, s, cnt, hi, lo, x;
    bit armed;
    longint f;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mn = 255; mx = 0; s = 0; cnt = 0; armed = 0;
      hi = (mid[ch] + HYST > 255) ? 255 : mid[ch] + HYST;
      lo = (mid[ch] - HYST < 0) ? 0 : mid[ch] - HYST;
      for (int i = 0; i < WIN; i++) begin
        x = win[ch][i];
        if (x < mn) mn = x;
        if (x > mx) mx = x;
        s += x;
        if (armed && x > hi) begin
          if (cnt < WIN - 1) cnt++;
          armed = 0;
        end else if (x < lo) begin
          armed = 1;
        end
      end
      f = (longint'(cnt) * longint'(FS_HZ)) / WIN;
      e_vpp[ch]  = mx - mn;
      e_dc[ch]   = s / WIN;
      e_freq[ch] = (f > 65535) ? 65535 : int'(f);
      e_ovf[ch]  = (cnt == WIN - 1) ? 1 : 0;
      mid[ch]    = e_dc[ch];
    end
  endfunction

  task automatic check_outputs_clear(input string tag);
    check_val({tag, "_busy"}, 32'(bus.busy), 0);
    check_val({tag, "_mv"}, 32'(bus.meas_valid), 0);
    check_val({tag, "_vpp"}, 32'(bus.vpp), 0);
    check_val({tag, "_dc"}, 32'(bus.dc_offset), 0);
    check_val({tag, "_freq"}, 32'(bus.freq_out), 0);
    check_val({tag, "_ovf"}, 32'(bus.cross_ovf), 0);
  endtask

  // One window of 512 accepted samples; abort_at >= 0 pulls rst_n low at that sample.
  task automatic run_window(input int abort_at, input bit drop_mode, input bit exp_busy_after);
    logic [NUM_CH*N-1:0] d;
    int gap;
    for (int i = 0; i < WIN; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        win[ch][i] = gen(ch, i);
        d[ch*N +: N] = N'(win[ch][i]);
      end
      bus.data_in   = d;
      bus.sample_en = 1'b1;
      if (i == 100) bus.start = 1'b1;
      if (drop_mode && i == 300) bus.mode_cont = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.sample_en = 1'b0;
        bus.start = 1'b0;
        #1;
        check_outputs_clear("async_rst");
        for (int ch = 0; ch < NUM_CH; ch++) mid[ch] = 128;
        return;
      end
      step();
      bus.sample_en = 1'b0;
      bus.start = 1'b0;
      check_val("mv_early", 32'(bus.meas_valid), 0);
      check_val("busy_acq", 32'(bus.busy), 1);
      if (i < WIN - 1) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          step();
          check_val("mv_early_gap", 32'(bus.meas_valid), 0);
        end
      end
    end
    model_window();
    // Strobes during CALC and PUB must not disturb anything.
    bus.sample_en = 1'b1;
    bus.data_in = (NUM_CH*N)'($urandom);
    step();
    check_val("mv_pulse", 32'(bus.meas_valid), 1);
    check_val("busy_pub", 32'(bus.busy), 1);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check_val($sformatf("vpp_ch%0d", ch), 32'(bus.vpp[ch*N +: N]), e_vpp[ch]);
      check_val($sformatf("dc_ch%0d", ch), 32'(bus.dc_offset[ch*N +: N]), e_dc[ch]);
      check_val($sformatf("freq_ch%0d", ch), 32'(bus.freq_out[ch*16 +: 16]), e_freq[ch]);
      check_val($sformatf("ovf_ch%0d", ch), 32'(bus.cross_ovf[ch]), e_ovf[ch]);
    end
    $display("[TB] window: vpp=%0d/%0d dc=%0d/%0d freq=%0d/%0d", e_vpp[0], e_vpp[1],
             e_dc[0], e_dc[1], e_freq[0], e_freq[1]);
    bus.data_in = (NUM_CH*N)'($urandom);
    step();
    bus.sample_en = 1'b0;
    check_val("mv_one_clk", 32'(bus.meas_valid), 0);
    check_val("busy_after", 32'(bus.busy), 32'(exp_busy_after));
    check_val("vpp_hold_ch0", 32'(bus.vpp[N-1:0]), e_vpp[0]);
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.start     = 1'b0;
    bus.mode_cont = 1'b0;
    bus.data_in   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mid[ch] = 128;
      phase[ch] = 0;
    end

    repeat (3) step();
    check_outputs_clear("reset");
    rst_n = 1'b1;
    step();
    check_val("idle_no_start", 32'(bus.busy), 0);

    // Single shot: ch0 flat at mid-scale, ch1 small noise inside the hysteresis band.
    pat[0] = P_CONST;
    pat[1] = P_NOISE;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_val("start_busy", 32'(bus.busy), 1);
    run_window(-1, 1'b0, 1'b0);
    check_val("flat_vpp", 32'(bus.vpp[7:0]), 0);
    check_val("flat_dc", 32'(bus.dc_offset[7:0]), 32'h80);
    check_val("flat_freq", 32'(bus.freq_out[15:0]), 0);
    repeat (5) begin
      step();
      check_val("idle_busy", 32'(bus.busy), 0);
      check_val("idle_mv", 32'(bus.meas_valid), 0);
    end

    // Continuous: ch0 square wave with random phase, ch1 noise.
    pat[0] = P_SQUARE;
    bus.mode_cont = 1'b1;
    step();
    check_val("cont_busy", 32'(bus.busy), 1);
    for (int w = 0; w < 3; w++) begin
      phase[0] = int'($urandom_range(0, 19));
      run_window(-1, 1'b0, 1'b1);
      check_val("noise_freq_ch1", 32'(bus.freq_out[31:16]), 0);
      check_val("noise_ovf_ch1", 32'(bus.cross_ovf[1]), 0);
    end

    // Full-scale alternation on ch0, random samples on ch1.
    pat[0] = P_ALT;
    phase[0] = 0;
    pat[1] = P_RAND;
    for (int w = 0; w < 2; w++) begin
      run_window(-1, 1'b0, 1'b1);
      check_val("alt_freq", 32'(bus.freq_out[15:0]), 10000);
      check_val("alt_vpp", 32'(bus.vpp[7:0]), 32'hFF);
      check_val("alt_dc", 32'(bus.dc_offset[7:0]), 32'h7F);
    end

    // Reset 300 samples into a window, then one clean window after release.
    pat[0] = P_RAND;
    pat[1] = P_SQUARE;
    phase[1] = int'($urandom_range(0, 19));
    run_window(300, 1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_val("rearm_busy", 32'(bus.busy), 1);
    run_window(-1, 1'b0, 1'b1);

    // Drop continuous mode mid-window: one more result, then idle.
    pat[0] = P_SQUARE;
    phase[0] = int'($urandom_range(0, 19));
    run_window(-1, 1'b1, 1'b0);
    repeat (20) begin
      step();
      check_val("drop_idle_busy", 32'(bus.busy), 0);
      check_val("drop_idle_mv", 32'(bus.meas_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
